// File: rtl/cog_seq_if.sv
// ---------------------------------------------------------------------------
// cog_seq_if
//    Bundles the cog RAM port and the ALU operand/result signals that the
//    cog sequencer exchanges with its surroundings.
//
//    Signals
//       ram_addr  [8:0]   RAM read/write address         (sequencer -> RAM)
//       ram_q     [31:0]  RAM read data, one cycle later (RAM -> sequencer)
//       ram_we            RAM write strobe               (sequencer -> RAM)
//       ram_wdata [31:0]  RAM write data                 (sequencer -> RAM)
//       alu_i     [5:0]   opcode                         (sequencer -> ALU)
//       alu_s     [31:0]  source operand                 (sequencer -> ALU)
//       alu_d     [31:0]  destination operand            (sequencer -> ALU)
//       alu_p     [8:0]   pc+1, for jmpret-style results (sequencer -> ALU)
//       alu_ci/zi         carry / zero flags in          (sequencer -> ALU)
//       alu_r     [31:0]  result                         (ALU -> sequencer)
//       alu_co/zo         carry / zero flags out         (ALU -> sequencer)
//       alu_wr            ALU allows result write-back   (ALU -> sequencer)
//
//    Modports
//       master : the sequencer (cog_seq)
//       slave  : RAM + ALU side
// ---------------------------------------------------------------------------
interface cog_seq_if;
   logic [8:0]  ram_addr;
   logic [31:0] ram_q;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [5:0]  alu_i;
   logic [31:0] alu_s;
   logic [31:0] alu_d;
   logic [8:0]  alu_p;
   logic        alu_ci;
   logic        alu_zi;
   logic [31:0] alu_r;
   logic        alu_co;
   logic        alu_zo;
   logic        alu_wr;

   modport master (
      output ram_addr, ram_we, ram_wdata,
      output alu_i, alu_s, alu_d, alu_p, alu_ci, alu_zi,
      input  ram_q, alu_r, alu_co, alu_zo, alu_wr
   );

   modport slave (
      input  ram_addr, ram_we, ram_wdata,
      input  alu_i, alu_s, alu_d, alu_p, alu_ci, alu_zi,
      output ram_q, alu_r, alu_co, alu_zo, alu_wr
   );
endinterface

// File: rtl/cog_seq.sv
// ---------------------------------------------------------------------------
// cog_seq
//    Four-phase instruction sequencer for a cog: I (fetch instruction),
//    S (read source), D (read destination), E (execute / write back).
//
//    Ports
//       clk_cog          single clock, rising edge
//       nres             asynchronous active-low reset
//       ena              cog enable; low forces restart at pc 0
//       hold             stall request, honoured only in E
//       bus (master)     RAM port and ALU operands/results (cog_seq_if)
//       pc    [8:0]      program counter
//       c, z             carry and zero flags
//       state [1:0]      current phase (00 I, 01 S, 10 D, 11 E)
//
//    Optional feature
//       COG_SEQ_FASTSKIP_EN  when defined, the execute condition is tested
//       in S straight from the fetched word; a false condition returns to I
//       with pc+1 after only two cycles. When undefined, false-condition
//       instructions run all four phases with writes and flag updates
//       suppressed.
// ---------------------------------------------------------------------------
module cog_seq (
   input  logic       clk_cog,
   input  logic       nres,
   input  logic       ena,
   input  logic       hold,
   cog_seq_if.master  bus,
   output logic [8:0] pc,
   output logic       c,
   output logic       z,
   output logic [1:0] state
);

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_D = 2'b10;
   localparam logic [1:0] ST_E = 2'b11;

   localparam logic [5:0] OP_JMP = 6'b010111;

   logic [31:0] ir;
   logic [31:0] s_reg;
   logic [8:0]  pc_inc;
   logic [3:0]  ir_cond;
   logic        cond_ok;
   logic        is_jmp;

   assign pc_inc  = pc + 9'd1;
   assign ir_cond = ir[21:18];
   // Flags only change when leaving E, so during the instruction they still
   // hold the values from its start.
   assign cond_ok = ir_cond[{c, z}];
   assign is_jmp  = (ir[31:26] == OP_JMP);

`ifdef COG_SEQ_FASTSKIP_EN
   logic [3:0] q_cond;
   logic       q_cond_ok;

   assign q_cond    = bus.ram_q[21:18];
   assign q_cond_ok = q_cond[{c, z}];
`endif

   // In S the instruction is still on ram_q (ir captures it at the end of
   // S), so the source address must be taken from ram_q directly.
   always_comb begin
      bus.ram_addr = ir[17:9];
      case (state)
         ST_I:    bus.ram_addr = pc;
         ST_S:    bus.ram_addr = bus.ram_q[8:0];
         default: bus.ram_addr = ir[17:9];
      endcase
   end

   // ena gates the strobe combinationally so a restart cycle never writes.
   assign bus.ram_we    = (state == ST_E) && ena && !hold && cond_ok &&
                          ir[23] && bus.alu_wr;
   assign bus.ram_wdata = bus.alu_r;

   assign bus.alu_i  = ir[31:26];
   assign bus.alu_s  = s_reg;
   assign bus.alu_d  = bus.ram_q;
   assign bus.alu_p  = pc_inc;
   assign bus.alu_ci = c;
   assign bus.alu_zi = z;

   always_ff @(posedge clk_cog or negedge nres) begin
      if (!nres) begin
         state <= ST_I;
         pc    <= 9'd0;
         c     <= 1'b0;
         z     <= 1'b0;
         ir    <= 32'd0;
         s_reg <= 32'd0;
      end else if (!ena) begin
         state <= ST_I;
         pc    <= 9'd0;
      end else begin
         case (state)
            ST_I: begin
               state <= ST_S;
            end
            ST_S: begin
               ir <= bus.ram_q;
`ifdef COG_SEQ_FASTSKIP_EN
               if (q_cond_ok) begin
                  state <= ST_D;
               end else begin
                  state <= ST_I;
                  pc    <= pc_inc;
               end
`else
               state <= ST_D;
`endif
            end
            ST_D: begin
               s_reg <= ir[22] ? {23'd0, ir[8:0]} : bus.ram_q;
               state <= ST_E;
            end
            default: begin
               if (!hold) begin
                  if (cond_ok) begin
                     if (ir[24]) c <= bus.alu_co;
                     if (ir[25]) z <= bus.alu_zo;
                  end
                  pc    <= (cond_ok && is_jmp) ? ir[8:0] : pc_inc;
                  state <= ST_I;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/cog_seq.md
COG_SEQ -- requirements
Module: cog_seq

Interface
REQ-001 SHALL provide port clk_cog  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL provide port nres  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port ena  input  1  cog enable; low holds sequencer at restart.
REQ-004 SHALL provide port hold  input  1  stall request, sampled in state E only.
REQ-005 SHALL provide port ram_addr  output  9  cog RAM read/write address.
REQ-006 SHALL provide port ram_q  input  32  cog RAM read data, valid the cycle after ram_addr.
REQ-007 SHALL provide ports ram_we  output  1  and ram_wdata  output  32  for RAM write at the clock edge.
REQ-008 SHALL provide ports alu_i (output, 6), alu_s (output, 32), alu_d (output, 32), alu_p (output, 9), alu_ci (output, 1), alu_zi (output, 1) to the ALU.
REQ-009 SHALL provide ports alu_r (input, 32), alu_co (input, 1), alu_zo (input, 1), alu_wr (input, 1) from the ALU.
REQ-010 SHALL provide ports pc (output, 9), c (output, 1), z (output, 1), state (output, 2).

Function
REQ-011 Instruction fields SHALL be: [31:26] opcode, [25] wz, [24] wc, [23] wr, [22] imm, [21:18] cond, [17:9] dst, [8:0] src.
REQ-012 State machine SHALL cycle I(00) -> S(01) -> D(10) -> E(11) -> I; ram_addr = pc in I, src in S, dst in D and E.
REQ-013 In S, the instruction register SHALL capture ram_q at the end of the cycle.
REQ-014 In D, the s register SHALL capture {23'b0, src} if imm=1, else ram_q.
REQ-015 In E: alu_d = ram_q; alu_s = s register; alu_i = opcode; alu_p = pc+1 (9-bit, wraps 511 -> 0); alu_ci = c; alu_zi = z.
REQ-016 Execute condition SHALL be cond[{c,z}] (bit index 2*c+z), evaluated against flags as held at start of the instruction.
REQ-017 In E with hold=0 and condition true: ram_we = wr & alu_wr; ram_wdata = alu_r; c <= alu_co if wc; z <= alu_zo if wz.
REQ-018 ram_we SHALL be 0 in every state other than E, and in E whenever hold=1 or condition false.
REQ-019 Leaving E, pc SHALL load src when opcode=010111 and condition true (jmp/jmpret), else pc+1 mod 512.
REQ-020 hold=1 in E SHALL keep state E, pc, flags, and instruction unchanged; no write; hold is ignored in I, S, D.
REQ-021 ena=0 SHALL, at the next edge, force state I, pc 0, and suppress ram_we in that cycle; flags retained.
REQ-022 Simultaneous ena=0 and hold=1 SHALL give ena priority.
REQ-023 A write to dst of the following instruction's src/dst SHALL be visible to its fetch (write completes before next I).

Reset
REQ-024 While nres=0: state I, pc 0, c 0, z 0, instruction and s registers 0, ram_we 0; asynchronous assertion mid-instruction SHALL abort it without a write.
REQ-025 After nres deasserts, first I cycle SHALL occur on the first edge with ena=1.

Configuration
REQ-026 Macro COG_SEQ_FASTSKIP_EN defined: condition evaluated in S on ram_q; if false, next state I, pc+1 (2-cycle skip, no D/E).
REQ-027 Macro COG_SEQ_FASTSKIP_EN undefined: false-condition instructions take full 4 cycles with writes and flag updates suppressed.

Verification
REQ-028 Reset, ena=1, RAM[0]=add(opcode 100000, wr=1, wc=1, wz=1, imm=1, cond=1111, dst=5, src=3), RAM[5]=0xFFFFFFFD -> cycle 4 writes 0 to RAM[5], c=1, z=1, pc=1.
REQ-029 Instruction with cond=0000 at pc=7 -> no write, flags unchanged, pc=8 after 4 cycles (2 with COG_SEQ_FASTSKIP_EN).
REQ-030 jmp (opcode 010111, imm=1, src=0x040, wr=0) at pc=0x1FF -> pc=0x040, ram_we never 1; non-jump at 0x1FF -> pc=0.
REQ-031 hold=1 for 3 cycles in E -> state stays 11, ram_we 0 during hold, single write on release cycle.
REQ-032 nres pulsed low during D -> state 00, pc 0, c/z 0, no RAM write observed.
REQ-033 ena dropped during E with hold=1 -> no write, state 00, pc 0 next edge.
